// File: rtl/tx_framer_pkg.sv
// tx_framer_pkg: framer state type and framing constants shared by tx_sample_framer.
package tx_framer_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} frameState;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int FRAME_LEN_BASE = 3;
  localparam int FRAME_LEN_CSUM = 4;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous power-of-two FIFO with occupancy count; pushes when full are dropped.
module sample_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] pushData,
  input  logic pop,
  output logic [W-1:0] popData,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign doPush = push & ~full;
  assign doPop = pop & ~empty;
  assign popData = mem[rdPtr];
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr] <= pushData;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(doPush);
      rdPtr <= rdPtr + AW'(doPop);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
endmodule

// File: rtl/tx_sample_framer.sv
// tx_sample_framer: buffers FIR samples and feeds them to the UART one framed byte at a time.
// Define TX_FRAMER_CHECKSUM_EN to append the XOR checksum byte to each frame.
module tx_sample_framer
  import tx_framer_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int FIFO_DEPTH = 8,
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  logic clk,
  input  logic rst,
  input  logic s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic s_ready,
  output logic tx_start,
  output logic [7:0] tx_data,
  input  logic tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic overflow
);
`ifdef TX_FRAMER_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN_CSUM - 1);
`else
  localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN_BASE - 1);
`endif
  frameState state, stateNext;
  logic [1:0] byteIdx, idxNext, idxInc;
  logic [15:0] frame, frameNext, popData, sampleExt;
  logic [7:0] dataNext, nextByte;
  logic full, empty, pop;
  assign sampleExt = 16'($signed(s_data));
  sample_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(s_valid), .pushData(sampleExt), .pop(pop),
    .popData(popData), .count(fifo_count), .full(full), .empty(empty)
  );
  assign s_ready = ~full;
  assign tx_start = state == START;
  assign idxInc = byteIdx + 2'd1;
`ifdef TX_FRAMER_CHECKSUM_EN
  assign nextByte = idxInc == 2'd1 ? frame[15:8] : idxInc == 2'd2 ? frame[7:0] : HEADER ^ frame[15:8] ^ frame[7:0];
`else
  assign nextByte = idxInc == 2'd1 ? frame[15:8] : frame[7:0];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) overflow <= 1'b0;
    else overflow <= overflow | (s_valid & full);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      byteIdx <= '0;
      frame <= '0;
      tx_data <= '0;
    end else begin
      state <= stateNext;
      byteIdx <= idxNext;
      frame <= frameNext;
      tx_data <= dataNext;
    end
  // Waiting for tx_busy=0 before every start keeps us off a byte still in flight after reset.
  always_comb begin
    stateNext = state;
    idxNext = byteIdx;
    frameNext = frame;
    dataNext = tx_data;
    pop = 1'b0;
    case (state)
      IDLE:
        if (!empty && !tx_busy) begin
          pop = 1'b1;
          frameNext = popData;
          idxNext = '0;
          dataNext = HEADER;
          stateNext = START;
        end
      START: stateNext = WAIT_BUSY;
      WAIT_BUSY: stateNext = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE:
        if (!tx_busy) begin
          if (byteIdx == LAST_IDX) stateNext = IDLE;
          else begin
            idxNext = idxInc;
            dataNext = nextByte;
            stateNext = START;
          end
        end
      default: stateNext = IDLE;
    endcase
  end
endmodule
